// File: rtl/pwm_gen_core.sv
// Multi-channel PWM generator with double-buffered (staging/active) configuration.
// Latency: pwm_out reflects the counter value of the previous cycle; staged config lands at a period boundary or while idle.
// Backpressure: none; cfg_load is a fire-and-forget pulse, and load_pending reports a staged update not yet applied.
//
// Ports:
//   ACLK, ARESETN  - clock, asynchronous active-low reset
//   cfg_enable     - level, 1 = run, 0 = idle
//   cfg_period     - requested period in ACLK cycles
//   cfg_duty       - per-channel high time, channel n at [n*W +: W]
//   cfg_polarity   - per-channel output inversion
//   cfg_load       - one-cycle pulse capturing cfg_* into staging
//   pwm_out        - registered PWM outputs
//   period_tick    - one-cycle pulse after each period wrap
//   load_pending   - staged update waiting for a boundary
//   cnt_value      - current period counter
module pwm_gen_core #(
  parameter int C_NUM_CH    = 4,
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            cfg_enable,
  input  logic [C_CNT_WIDTH-1:0]          cfg_period,
  input  logic [C_NUM_CH*C_CNT_WIDTH-1:0] cfg_duty,
  input  logic [C_NUM_CH-1:0]             cfg_polarity,
  input  logic                            cfg_load,
  output logic [C_NUM_CH-1:0]             pwm_out,
  output logic                            period_tick,
  output logic                            load_pending,
  output logic [C_CNT_WIDTH-1:0]          cnt_value
);

  localparam int W = C_CNT_WIDTH;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [0:0]            state_q, state_d;
  logic [W-1:0]          cnt_q, cnt_d;
  logic [W-1:0]          stg_period_q, stg_period_d;
  logic [C_NUM_CH*W-1:0] stg_duty_q, stg_duty_d;
  logic [C_NUM_CH-1:0]   stg_pol_q, stg_pol_d;
  logic [W-1:0]          act_period_q, act_period_d;
  logic [C_NUM_CH*W-1:0] act_duty_q, act_duty_d;
  logic [C_NUM_CH-1:0]   act_pol_q, act_pol_d;
  logic                  pend_q, pend_d;
  logic                  tick_q, tick_d;
  logic [C_NUM_CH-1:0]   pwm_q, pwm_d;

  logic         degen;
  logic         running;
  logic         wrap;
  logic         direct_load;
  logic         apply_stg;
  logic [W-1:0] period_m1;

  // Period 0 or 1 cannot produce a meaningful waveform: freeze at count 0.
  assign degen     = (act_period_q[W-1:1] == '0);
  assign running   = (state_q == ST_RUN) && cfg_enable && !degen;
  assign period_m1 = act_period_q - ONE;
  // Counter never exceeds period-1 (active period only changes at count 0),
  // so >= is equivalent to == but robust.
  assign wrap      = running && (cnt_q >= period_m1);
  // A load landing exactly on the wrap bypasses staging entirely.
  assign direct_load = cfg_load && wrap;
  // Staged values are safe to apply whenever no period is in progress.
  assign apply_stg   = pend_q && ((state_q == ST_IDLE) || degen || wrap);

  always_comb begin
    state_d      = cfg_enable ? ST_RUN : ST_IDLE;
    cnt_d        = (running && !wrap) ? (cnt_q + ONE) : '0;
    tick_d       = wrap;
    pwm_d        = act_pol_q;
    stg_period_d = stg_period_q;
    stg_duty_d   = stg_duty_q;
    stg_pol_d    = stg_pol_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_pol_d    = act_pol_q;
    pend_d       = pend_q;

    if (running) begin
      for (int n = 0; n < C_NUM_CH; n++) begin
        pwm_d[n] = (cnt_q < act_duty_q[n*W +: W]) ^ act_pol_q[n];
      end
    end

    if (direct_load) begin
      stg_period_d = cfg_period;
      stg_duty_d   = cfg_duty;
      stg_pol_d    = cfg_polarity;
      act_period_d = cfg_period;
      act_duty_d   = cfg_duty;
      act_pol_d    = cfg_polarity;
      pend_d       = 1'b0;
    end else begin
      if (apply_stg) begin
        act_period_d = stg_period_q;
        act_duty_d   = stg_duty_q;
        act_pol_d    = stg_pol_q;
        pend_d       = 1'b0;
      end
      // A new load overrides the clear above: the fresh values still wait.
      if (cfg_load) begin
        stg_period_d = cfg_period;
        stg_duty_d   = cfg_duty;
        stg_pol_d    = cfg_polarity;
        pend_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stg_period_q <= '0;
      stg_duty_q   <= '0;
      stg_pol_q    <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_pol_q    <= '0;
      pend_q       <= 1'b0;
      tick_q       <= 1'b0;
      pwm_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stg_period_q <= stg_period_d;
      stg_duty_q   <= stg_duty_d;
      stg_pol_q    <= stg_pol_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_pol_q    <= act_pol_d;
      pend_q       <= pend_d;
      tick_q       <= tick_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_tick  = tick_q;
  assign load_pending = pend_q;
  assign cnt_value    = cnt_q;

endmodule

// File: tb/tb_pwm_gen_core.sv
module tb_pwm_gen_core;

  localparam int NCH = 4;
  localparam int CW  = 32;
  typedef logic [NCH+2+CW-1:0] vec_t;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b1;
  logic              cfg_enable = 1'b0;
  logic [CW-1:0]     cfg_period = '0;
  logic [NCH*CW-1:0] cfg_duty = '0;
  logic [NCH-1:0]    cfg_polarity = '0;
  logic              cfg_load = 1'b0;
  logic [NCH-1:0]    pwm_out;
  logic              period_tick;
  logic              load_pending;
  logic [CW-1:0]     cnt_value;

  int checks = 0;
  int fails  = 0;

  pwm_gen_core #(.C_NUM_CH(NCH), .C_CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_polarity(cfg_polarity),
    .cfg_load(cfg_load), .pwm_out(pwm_out), .period_tick(period_tick),
    .load_pending(load_pending), .cnt_value(cnt_value)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  // Expected outputs after the most recent edge.
  bit             m_run;
  int unsigned    m_cnt;
  bit             m_tick, m_pend;
  logic [NCH-1:0] m_pwm;
  int unsigned    s_per, a_per;
  int unsigned    s_duty[NCH], a_duty[NCH];
  logic [NCH-1:0] s_pol, a_pol;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_tick = 0; m_pend = 0; m_pwm = '0;
    s_per = 0; a_per = 0; s_pol = '0; a_pol = '0;
    for (int n = 0; n < NCH; n++) begin s_duty[n] = 0; a_duty[n] = 0; end
  endtask

  // One clock edge, described by the rules of the block.
  task automatic model_step();
    bit counting, at_wrap;
    counting = m_run && cfg_enable && (a_per >= 2);
    at_wrap  = counting && (m_cnt + 1 == a_per);
    m_tick   = at_wrap;
    for (int n = 0; n < NCH; n++)
      m_pwm[n] = counting ? ((m_cnt < a_duty[n]) ^ a_pol[n]) : a_pol[n];
    m_cnt = (counting && !at_wrap) ? m_cnt + 1 : 0;
    if (cfg_load && at_wrap) begin
      s_per = cfg_period; a_per = cfg_period;
      s_pol = cfg_polarity; a_pol = cfg_polarity;
      for (int n = 0; n < NCH; n++) begin
        s_duty[n] = cfg_duty[n*CW +: CW]; a_duty[n] = cfg_duty[n*CW +: CW];
      end
      m_pend = 0;
    end else begin
      if (m_pend && (!m_run || a_per < 2 || at_wrap)) begin
        a_per = s_per; a_pol = s_pol; a_duty = s_duty; m_pend = 0;
      end
      if (cfg_load) begin
        s_per = cfg_period; s_pol = cfg_polarity;
        for (int n = 0; n < NCH; n++) s_duty[n] = cfg_duty[n*CW +: CW];
        m_pend = 1;
      end
    end
    m_run = cfg_enable;
  endtask

  task automatic tick();
    @(posedge ACLK);
    if (!ARESETN) model_reset(); else model_step();
    #1;
  endtask

  function automatic vec_t act_vec();
    return {pwm_out, period_tick, load_pending, cnt_value};
  endfunction

  function automatic vec_t exp_vec();
    return {m_pwm, m_tick, m_pend, m_cnt};
  endfunction

  task automatic set_cfg(input int unsigned per, input int unsigned d0, input int unsigned d1,
                         input int unsigned d2, input int unsigned d3, input logic [NCH-1:0] pol);
    cfg_period   = per;
    cfg_duty     = {d3, d2, d1, d0};
    cfg_polarity = pol;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 ARESETN = 1'b0;
    #2;
    checks++;
    if (act_vec() !== '0) begin fails++; $display("FAIL reset_async: got %h want 0", act_vec()); end
    model_reset();
    tick(); tick();
    checks++;
    if (act_vec() !== exp_vec()) begin fails++; $display("FAIL reset_held: got %h want %h", act_vec(), exp_vec()); end
    #2 ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL reset_idle c%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
  endtask

  task automatic test_basic();
    int hi, tk;
    hi = 0; tk = 0;
    set_cfg(10, 3, $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
            {3'($urandom), 1'b0});
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1) begin fails++; $display("FAIL basic_pending: got %b want 1", load_pending); end
    cfg_enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL basic c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      if (i >= 10) begin hi += int'(pwm_out[0]); tk += int'(period_tick); end
    end
    checks++;
    if (hi != 6 || tk != 2) begin fails++; $display("FAIL basic_shape: high %0d ticks %0d, want 6 and 2", hi, tk); end
  endtask

  task automatic test_reload();
    bit found;
    int t1, t2, hi;
    found = 0; t1 = -1; t2 = -1; hi = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 4) found = 1;
      else begin
        tick(); checks++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL reload_wait c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      end
    end
    checks++;
    if (!found) begin fails++; $display("FAIL reload_timeout: count 4 not reached"); end
    set_cfg(20, 5, $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), cfg_polarity);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1) begin fails++; $display("FAIL reload_pending: got %b want 1", load_pending); end
    for (int i = 0; i < 50; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL reload c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      if (period_tick === 1'b1) begin
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
      if (t1 >= 0 && i > t1 && i <= t1 + 20) hi += int'(pwm_out[0]);
    end
    checks++;
    if (t1 != 4 || t2 - t1 != 20 || hi != 5) begin
      fails++; $display("FAIL reload_shape: first tick %0d gap %0d high %0d, want 4 20 5", t1, t2 - t1, hi);
    end
  endtask

  task automatic test_duty_edges();
    int h1, h2, h3;
    h1 = 0; h2 = 0; h3 = 0;
    set_cfg(10, 3, 0, 15, 4, 4'b1000);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL duty c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      if (i >= 30) begin h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]); h3 += int'(pwm_out[3]); end
    end
    checks++;
    if (h1 != 0 || h2 != 20 || h3 != 12) begin
      fails++; $display("FAIL duty_shape: ch1 %0d ch2 %0d ch3 %0d, want 0 20 12", h1, h2, h3);
    end
  endtask

  task automatic test_disable();
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 5) found = 1;
      else begin
        tick(); checks++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL dis_wait c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      end
    end
    checks++;
    if (!found) begin fails++; $display("FAIL dis_timeout: count 5 not reached"); end
    cfg_enable = 1'b0;
    tick(); checks++;
    if (cnt_value !== 0 || pwm_out !== 4'b1000 || period_tick !== 1'b0) begin
      fails++; $display("FAIL dis_edge: cnt %0d pwm %b tick %b, want 0 1000 0", cnt_value, pwm_out, period_tick);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL dis_idle c%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
    cfg_enable = 1'b1;
    tick(); tick(); checks++;
    if (cnt_value !== 1) begin fails++; $display("FAIL dis_restart: cnt %0d want 1", cnt_value); end
    for (int i = 0; i < 12; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL dis_rerun c%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
  endtask

  task automatic test_degenerate();
    int tk;
    bit found, pend_seen;
    tk = 0; found = 0; pend_seen = 0;
    set_cfg(0, 5, 5, 5, 5, 4'b0101);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL degen c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      if (i >= 15) tk += int'(period_tick);
    end
    checks++;
    if (tk != 0 || pwm_out !== 4'b0101 || cnt_value !== 0) begin
      fails++; $display("FAIL degen_hold: ticks %0d pwm %b cnt %0d, want 0 0101 0", tk, pwm_out, cnt_value);
    end
    set_cfg(1, 1, 1, 1, 1, 4'b0000);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    set_cfg(8, 2, 6, 9, 0, 4'b0000);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick(); checks++;
    if (load_pending !== 1'b0) begin fails++; $display("FAIL degen_apply: pending %b want 0", load_pending); end
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 7) found = 1;
      else begin
        tick(); checks++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL wrapload_wait c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      end
    end
    checks++;
    if (!found) begin fails++; $display("FAIL wrapload_timeout: count 7 not reached"); end
    set_cfg(6, 1, 2, 3, 4, 4'b0011);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    checks++;
    if (load_pending !== 1'b0 || period_tick !== 1'b1) begin
      fails++; $display("FAIL wrapload_edge: pending %b tick %b, want 0 1", load_pending, period_tick);
    end
    tk = 0;
    for (int i = 1; i <= 18; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL wrapload c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      pend_seen |= load_pending; tk += int'(period_tick);
    end
    checks++;
    if (pend_seen || tk != 3) begin fails++; $display("FAIL wrapload_shape: pending seen %b ticks %0d, want 0 3", pend_seen, tk); end
  endtask

  task automatic test_async_reset();
    bit found, active;
    found = 0; active = 0;
    set_cfg(10, 3, 7, 0, 10, 4'b0110);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_cnt == 6 && a_per == 10) found = 1;
      else begin
        tick(); checks++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL arst_wait c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      end
    end
    checks++;
    if (!found) begin fails++; $display("FAIL arst_timeout: count 6 not reached"); end
    set_cfg(12, 4, 4, 4, 4, 4'b1111);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    checks++;
    if (cnt_value !== 7 || load_pending !== 1'b1) begin
      fails++; $display("FAIL arst_pre: cnt %0d pending %b, want 7 1", cnt_value, load_pending);
    end
    #2 ARESETN = 1'b0;
    #1; checks++;
    if (pwm_out !== '0 || cnt_value !== 0 || load_pending !== 1'b0 || period_tick !== 1'b0) begin
      fails++; $display("FAIL arst_now: pwm %b cnt %0d pending %b tick %b, want all 0", pwm_out, cnt_value, load_pending, period_tick);
    end
    model_reset();
    tick(); tick();
    #2 ARESETN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL arst_after c%0d: got %h want %h", i, act_vec(), exp_vec()); end
      if (cnt_value !== 0 || pwm_out !== '0 || period_tick !== 1'b0) active = 1;
    end
    checks++;
    if (active) begin fails++; $display("FAIL arst_stays_idle: activity without cfg_load"); end
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL arst_rerun c%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                $urandom_range(0, 14), $urandom_range(0, 14), 4'($urandom));
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) cfg_enable = ~cfg_enable;
      tick(); checks++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL random c%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
    cfg_load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_reload();
    test_duty_edges();
    test_disable();
    test_degenerate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
